// File: rtl/alarm_timer_bank_pkg.sv
// Shared types and constants for the multi-channel mm:ss alarm timer bank.
package alarm_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_PAUSE   = 2'b10,
    ST_EXPIRED = 2'b11
  } chan_state_e;

  localparam int unsigned BTN_MIN = 3;
  localparam int unsigned BTN_SEC = 2;
  localparam int unsigned BTN_CLR = 1;
  localparam int unsigned BTN_GO  = 0;

  localparam int unsigned SS_MAX = 59;

  // Clock mode in which the panel edits the alarm timers
  localparam logic [1:0] MODE_ALARM = 2'b10;

  // Increment with wrap to zero past max
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/alarm_timer_bank_channel.sv
// One countdown channel: FSM, count, preset and ring/expiry logic.
// Optional ring auto-timeout built when ALARM_RING_TIMEOUT_EN is defined.
module alarm_timer_channel
  import alarm_timer_pkg::*;
#(
  parameter int unsigned MM_MAX = 59
`ifdef ALARM_RING_TIMEOUT_EN
  , parameter int unsigned RING_SEC = 30
`endif
) (
  input  logic        wt_clk,
  input  logic        rst_n,
  input  logic        edit_en,
  input  logic [3:0]  act,
  input  logic        tick,
  output logic [5:0]  mm,
  output logic [5:0]  ss,
  output logic [1:0]  state,
  output logic        ring,
  output logic        expire_pulse
);

  chan_state_e state_q, state_d;
  logic [5:0]  mm_q, mm_d, ss_q, ss_d;
  logic [5:0]  mm_p_q, mm_p_d, ss_p_q, ss_p_d;
  logic        expire_q, expire_d;
  logic        nonzero;
`ifdef ALARM_RING_TIMEOUT_EN
  logic [7:0]  ring_cnt_q, ring_cnt_d;
`endif

  assign nonzero = (mm_q != 6'd0) || (ss_q != 6'd0);

  // Next-state, count and preset logic; act is already one-hot after priority decode
  always_comb begin
    state_d  = state_q;
    mm_d     = mm_q;
    ss_d     = ss_q;
    mm_p_d   = mm_p_q;
    ss_p_d   = ss_p_q;
    expire_d = 1'b0;
`ifdef ALARM_RING_TIMEOUT_EN
    ring_cnt_d = ring_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (edit_en) begin
          if (act[BTN_CLR]) begin
            mm_d = 6'd0;
            ss_d = 6'd0;
          end else if (act[BTN_GO]) begin
            if (nonzero) begin
              mm_p_d  = mm_q;
              ss_p_d  = ss_q;
              state_d = ST_RUN;
            end
          end else if (act[BTN_MIN]) begin
            mm_d = wrap_inc(mm_q, 6'(MM_MAX));
          end else if (act[BTN_SEC]) begin
            ss_d = wrap_inc(ss_q, 6'(SS_MAX));
          end
        end
      end
      ST_RUN: begin
        // An accepted button on this channel swallows a coincident tick
        if (edit_en && (act != 4'd0)) begin
          if (act[BTN_CLR]) begin
            mm_d    = mm_p_q;
            ss_d    = ss_p_q;
            state_d = ST_IDLE;
          end else if (act[BTN_GO]) begin
            state_d = ST_PAUSE;
          end
        end else if (tick) begin
          if (ss_q != 6'd0) begin
            ss_d = ss_q - 6'd1;
            if ((mm_q == 6'd0) && (ss_q == 6'd1)) begin
              state_d  = ST_EXPIRED;
              expire_d = 1'b1;
            end
          end else if (mm_q != 6'd0) begin
            mm_d = mm_q - 6'd1;
            ss_d = 6'(SS_MAX);
          end
        end
      end
      ST_PAUSE: begin
        if (edit_en) begin
          if (act[BTN_CLR]) begin
            mm_d    = mm_p_q;
            ss_d    = ss_p_q;
            state_d = ST_IDLE;
          end else if (act[BTN_GO]) begin
            // Edits may leave 00:00; resuming that would never expire
            if (nonzero) state_d = ST_RUN;
          end else if (act[BTN_MIN]) begin
            mm_d = wrap_inc(mm_q, 6'(MM_MAX));
          end else if (act[BTN_SEC]) begin
            ss_d = wrap_inc(ss_q, 6'(SS_MAX));
          end
        end
      end
      ST_EXPIRED: begin
        if (act != 4'd0) begin
          mm_d    = mm_p_q;
          ss_d    = ss_p_q;
          state_d = ST_IDLE;
`ifdef ALARM_RING_TIMEOUT_EN
          ring_cnt_d = 8'd0;
        end else if (tick) begin
          if (ring_cnt_q == 8'(RING_SEC - 1)) begin
            mm_d       = mm_p_q;
            ss_d       = ss_p_q;
            state_d    = ST_IDLE;
            ring_cnt_d = 8'd0;
          end else begin
            ring_cnt_d = ring_cnt_q + 8'd1;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Channel registers
  always_ff @(posedge wt_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mm_q     <= '0;
      ss_q     <= '0;
      mm_p_q   <= '0;
      ss_p_q   <= '0;
      expire_q <= 1'b0;
`ifdef ALARM_RING_TIMEOUT_EN
      ring_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      mm_q     <= mm_d;
      ss_q     <= ss_d;
      mm_p_q   <= mm_p_d;
      ss_p_q   <= ss_p_d;
      expire_q <= expire_d;
`ifdef ALARM_RING_TIMEOUT_EN
      ring_cnt_q <= ring_cnt_d;
`endif
    end
  end

  assign mm           = mm_q;
  assign ss           = ss_q;
  assign state        = state_q;
  assign ring         = (state_q == ST_EXPIRED);
  assign expire_pulse = expire_q;

endmodule

// File: rtl/alarm_timer_bank.sv
// Multi-channel mm:ss countdown alarm bank: button priority decode,
// per-channel instances and selected-channel output mux.
// Optional ring auto-timeout: define ALARM_RING_TIMEOUT_EN.
module alarm_timer_bank
  import alarm_timer_pkg::*;
#(
  parameter int unsigned CH       = 4,
  parameter int unsigned MM_MAX   = 59,
  parameter int unsigned RING_SEC = 30
) (
  input  logic                                  wt_clk,
  input  logic                                  rst_n,
  input  logic [1:0]                            st,
  input  logic [3:0]                            btn,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] sel,
  input  logic                                  tick_1hz,
  output logic [5:0]                            mm_out,
  output logic [5:0]                            ss_out,
  output logic [1:0]                            state_out,
  output logic [CH-1:0]                         ring,
  output logic [CH-1:0]                         expire_pulse
);

  localparam int unsigned SW = (CH > 1) ? $clog2(CH) : 1;

  if ((CH < 1) || (CH > 8) || (MM_MAX < 1) || (MM_MAX > 63) ||
      (RING_SEC < 1) || (RING_SEC > 255)) begin : g_param_err
    $error("alarm_timer_bank: parameter out of range");
  end

  logic [3:0] act   [CH];
  logic [5:0] ch_mm [CH];
  logic [5:0] ch_ss [CH];
  logic [1:0] ch_st [CH];
  logic       edit_en;

  assign edit_en = (st == MODE_ALARM);

  // Route the single winning button action to the selected channel only
  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      act[i] = '0;
      if (sel == SW'(i)) begin
        if (btn[BTN_CLR])      act[i][BTN_CLR] = 1'b1;
        else if (btn[BTN_GO])  act[i][BTN_GO]  = 1'b1;
        else if (btn[BTN_MIN]) act[i][BTN_MIN] = 1'b1;
        else if (btn[BTN_SEC]) act[i][BTN_SEC] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    alarm_timer_channel #(
      .MM_MAX   (MM_MAX)
`ifdef ALARM_RING_TIMEOUT_EN
      , .RING_SEC (RING_SEC)
`endif
    ) u_ch (
      .wt_clk       (wt_clk),
      .rst_n        (rst_n),
      .edit_en      (edit_en),
      .act          (act[g]),
      .tick         (tick_1hz),
      .mm           (ch_mm[g]),
      .ss           (ch_ss[g]),
      .state        (ch_st[g]),
      .ring         (ring[g]),
      .expire_pulse (expire_pulse[g])
    );
  end

  // Selected-channel display mux; out-of-range selects read zero
  always_comb begin
    mm_out    = '0;
    ss_out    = '0;
    state_out = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (sel == SW'(i)) begin
        mm_out    = ch_mm[i];
        ss_out    = ch_ss[i];
        state_out = ch_st[i];
      end
    end
  end

endmodule

// File: tb/tb_alarm_timer_bank.sv
// Directed self-checking bench for alarm_timer_bank (CH=4, MM_MAX=59, RING_SEC=3).
module tb_alarm_timer_bank;

  logic       wt_clk = 1'b0;
  logic       rst_n;
  logic [1:0] st;
  logic [3:0] btn;
  logic [1:0] sel;
  logic       tick_1hz;
  logic [5:0] mm_out, ss_out;
  logic [1:0] state_out;
  logic [3:0] ring, expire_pulse;

  int checks = 0;
  int errors = 0;
  int pulses;

  alarm_timer_bank #(
    .CH       (4),
    .MM_MAX   (59),
    .RING_SEC (3)
  ) dut (
    .wt_clk       (wt_clk),
    .rst_n        (rst_n),
    .st           (st),
    .btn          (btn),
    .sel          (sel),
    .tick_1hz     (tick_1hz),
    .mm_out       (mm_out),
    .ss_out       (ss_out),
    .state_out    (state_out),
    .ring         (ring),
    .expire_pulse (expire_pulse)
  );

  always #5 wt_clk = ~wt_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ch(input string tag, input int mm, input int ss, input int stt);
    chk({tag, ".mm"},    32'(mm_out),    mm);
    chk({tag, ".ss"},    32'(ss_out),    ss);
    chk({tag, ".state"}, 32'(state_out), stt);
  endtask

  // Present inputs for one rising edge, then sample just after it
  task automatic step(input logic [3:0] b, input logic t);
    btn      = b;
    tick_1hz = t;
    @(posedge wt_clk);
    #1;
    btn      = 4'd0;
    tick_1hz = 1'b0;
  endtask

  task automatic press(input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    st       = 2'b00;
    btn      = 4'd0;
    sel      = 2'd0;
    tick_1hz = 1'b0;
    repeat (2) @(posedge wt_clk);
    #1;
    // Reset state
    chk("rst.ring",   32'(ring),         0);
    chk("rst.expire", 32'(expire_pulse), 0);
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      chk_ch("rst.ch", 0, 0, 0);
    end
    rst_n = 1'b1;
    step(4'd0, 1'b0);

    // Channel 2: 03:02 countdown to expiry
    st  = 2'b10;
    sel = 2'd2;
    press(4'b1000, 3);
    press(4'b0100, 2);
    chk_ch("ch2.edit", 3, 2, 0);
    step(4'b0001, 1'b0);
    chk_ch("ch2.start", 3, 2, 1);
    pulses = 0;
    for (int i = 0; i < 181; i++) begin
      step(4'd0, 1'b1);
      if (expire_pulse[2]) pulses++;
    end
    chk_ch("ch2.t181", 0, 1, 1);
    chk("ch2.t181.pulses", 32'(pulses), 0);
    step(4'd0, 1'b1);
    chk("ch2.t182.expire", 32'(expire_pulse), 4'b0100);
    chk("ch2.t182.ring",   32'(ring),         4'b0100);
    chk_ch("ch2.t182", 0, 0, 3);
    step(4'd0, 1'b0);
    chk("ch2.after.expire", 32'(expire_pulse), 0);
    chk("ch2.after.ring",   32'(ring),         4'b0100);
    sel = 2'd0; #1; chk_ch("ch0.untouched", 0, 0, 0);
    sel = 2'd1; #1; chk_ch("ch1.untouched", 0, 0, 0);
    sel = 2'd3; #1; chk_ch("ch3.untouched", 0, 0, 0);

    // Ring hold/acknowledge or timeout on channel 2
    sel = 2'd2;
    st  = 2'b00;
`ifdef ALARM_RING_TIMEOUT_EN
    press(4'd0, 0);
    step(4'd0, 1'b1);
    step(4'd0, 1'b1);
    chk("ring.to.t2", 32'(ring), 4'b0100);
    step(4'd0, 1'b1);
    chk("ring.to.t3", 32'(ring), 0);
    chk_ch("ring.to.reload", 3, 2, 0);
`else
    for (int i = 0; i < 10; i++) step(4'd0, 1'b1);
    chk("ring.hold", 32'(ring), 4'b0100);
    chk_ch("ring.hold", 0, 0, 3);
    step(4'b0001, 1'b0);
    chk("ring.ack", 32'(ring), 0);
    chk_ch("ring.ack.reload", 3, 2, 0);
`endif

    // Edit wrap on channel 1
    st  = 2'b10;
    sel = 2'd1;
    press(4'b0100, 60);
    chk_ch("wrap.sec", 0, 0, 0);
    press(4'b1000, 59);
    chk_ch("wrap.min59", 59, 0, 0);
    step(4'b1000, 1'b0);
    chk_ch("wrap.min0", 0, 0, 0);
    step(4'b0001, 1'b0);
    chk_ch("start.zero", 0, 0, 0);
    step(4'b1100, 1'b0);
    chk_ch("prio.min.sec", 1, 0, 0);

    // Channel 0 pause/resume/clear
    sel = 2'd0;
    press(4'b0100, 10);
    step(4'b0001, 1'b0);
    chk_ch("ch0.run", 0, 10, 1);
    step(4'b0001, 1'b0);
    for (int i = 0; i < 5; i++) step(4'd0, 1'b1);
    chk_ch("ch0.pause", 0, 10, 2);
    step(4'b0001, 1'b0);
    for (int i = 0; i < 3; i++) step(4'd0, 1'b1);
    chk_ch("ch0.resume", 0, 7, 1);
    step(4'b0010, 1'b0);
    chk_ch("ch0.clear", 0, 10, 0);

    // Clear beats start/pause on a running channel
    step(4'b0001, 1'b0);
    step(4'd0, 1'b1);
    step(4'd0, 1'b1);
    chk_ch("prio.pre", 0, 8, 1);
    step(4'b0011, 1'b0);
    chk_ch("prio.clr", 0, 10, 0);

    // Button and tick together: selected channel drops tick, other still counts
    step(4'b0001, 1'b0);
    sel = 2'd3;
    press(4'b0100, 5);
    step(4'b0001, 1'b0);
    chk_ch("ch3.run", 0, 5, 1);
    sel = 2'd0;
    step(4'b0001, 1'b1);
    chk_ch("coll.ch0", 0, 10, 2);
    sel = 2'd3; #1;
    chk_ch("coll.ch3", 0, 4, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_timer_bank.md
# alarm_timer_bank

Parametrised multi-channel countdown alarm, successor to the single-channel mm:ss alarm in the digital clock. It holds `CH` independent mm:ss timers, edited and started from the shared four-button panel while the clock is in alarm mode (`st == 2'b10`). All channels count down in parallel on a 1 Hz strobe and raise a per-channel ring flag on expiry. The selected channel's time and state drive the display path.

## Interface
Parameters:
- `CH`, 4: number of timer channels (1..8).
- `MM_MAX`, 59: maximum settable minutes (1..63).
- `RING_SEC`, 30: ring duration in ticks when timeout is compiled in (1..255).

Ports:
- `wt_clk`, input, 1: system clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `st`, input, 2: clock mode; editing is enabled only at `2'b10`.
- `btn`, input, 4: single-cycle, debounced button pulses. Bit 3 = min+, bit 2 = sec+, bit 1 = clear, bit 0 = start/pause.
- `sel`, input, `$clog2(CH)` (min 1): channel addressed by buttons and display.
- `tick_1hz`, input, 1: one-cycle count enable.
- `mm_out`, output, 6: minutes of channel `sel`.
- `ss_out`, output, 6: seconds of channel `sel`.
- `state_out`, output, 2: state of channel `sel`.
- `ring`, output, `CH`: per-channel ringing flag.
- `expire_pulse`, output, `CH`: one-cycle pulse at expiry.

## Operation
- Per-channel state: IDLE=00, RUN=01, PAUSE=10, EXPIRED=11. Each channel also holds a count `mm`/`ss` and a preset `mm_p`/`ss_p`.
- Buttons act only on channel `sel`. Priority when several bits are set: clear > start/pause > min+ > sec+. Only the winning action executes.
- With `st != 2'b10`, buttons are ignored, except on an EXPIRED channel (see acknowledge below).
- IDLE:
  - min+: `mm` wraps `MM_MAX` -> 0.
  - sec+: `ss` wraps 59 -> 0.
  - clear: `mm`, `ss` <= 0.
  - start: copy `mm`/`ss` into the preset, go to RUN. Start is ignored when the count is 00:00.
- RUN:
  - On `tick_1hz`: if `ss > 0`, `ss--`; else if `mm > 0`, `mm--` and `ss <= 59`.
  - 00:01 -> 00:00 goes to EXPIRED, asserts `expire_pulse` for one cycle and sets `ring`.
  - start/pause goes to PAUSE. clear goes to IDLE and reloads the preset. min+/sec+ are ignored.
- PAUSE:
  - Count frozen. min+/sec+ edit as in IDLE.
  - start resumes RUN. clear goes to IDLE and reloads the preset.
- EXPIRED:
  - Any button pulse on the selected channel (acknowledge, regardless of `st`) clears `ring`, goes to IDLE and reloads the preset.
- Reset: all channels go to IDLE with count 00:00 and preset 00:00. `ring` = 0, `expire_pulse` = 0, `mm_out`/`ss_out`/`state_out` = 0. Reset mid-count abandons the count with no expiry pulse.

## Timing
- State, count, `ring` and `expire_pulse` are registered. They update on the `wt_clk` edge that samples the button or tick.
- `expire_pulse`/`ring` rise in the cycle after the edge that samples the final tick.
- `mm_out`/`ss_out`/`state_out` are a combinational mux of registers, so a change of `sel` is visible in the same cycle.
- Button and tick in the same cycle on the selected channel: the button wins and that tick is dropped for that channel. Non-selected channels still consume the tick.
- Out-of-range `sel` (>= `CH`): buttons are ignored and the outputs read 0.

## Configuration
- `ALARM_RING_TIMEOUT_EN` defined: each channel counts ticks while EXPIRED. After `RING_SEC` ticks it auto-clears `ring`, goes to IDLE and reloads the preset. A button acknowledge before that still applies immediately.
- Not defined: `ring` stays set until acknowledged, and the timeout counter is not built.

## Structure
- Package `alarm_timer_pkg` holds:
  - the state enum,
  - button index constants `BTN_MIN`=3, `BTN_SEC`=2, `BTN_CLR`=1, `BTN_GO`=0,
  - `SS_MAX`=59.
- Sub-module `alarm_timer_channel`: one channel's FSM, count, preset and ring logic. It takes a decoded per-channel button vector and the tick, and is instantiated `CH` times with a generate loop.
- The top level does button decode/priority and the output mux.

## Test plan
- Reset with `CH`=4: every channel IDLE at 00:00, `ring` = 4'b0000, outputs 0.
- `sel`=2, `st`=10: 3× min+, 2× sec+, start, then 182 ticks -> `expire_pulse[2]` for exactly one cycle after the 182nd tick, `ring[2]`=1, other channels untouched.
- Edit wrap: sec+ ×60 from 00:00 -> 00:00. min+ at `MM_MAX` -> 00. Start at 00:00 -> state stays IDLE.
- Channel 0 RUN at 00:10: pause, 5 ticks -> still 00:10. Resume, then 3 ticks -> 00:07. Clear -> IDLE at preset 00:10.
- `btn`=4'b0011 on a RUN channel -> clear wins (IDLE at preset). Button and tick in the same cycle on `sel` -> tick dropped, while a second RUN channel still decrements.
- With `ALARM_RING_TIMEOUT_EN`, `RING_SEC`=3: `ring` clears after 3 ticks. Without it: `ring` holds for 10 ticks and clears on `btn`=0001 while `st`=00.
